// File: rtl/multi_iter.sv
// Iterative shift-add multiplier: operand FIFO feeding a one-bit-per-cycle engine.
// Optional MULTI_EARLY_DONE_EN ends an iteration once the remaining multiplier is zero.
module multi_iter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_W-1:0]     in0_data,
  input  logic [DATA_W-1:0]     in1_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [2*DATA_W-1:0]   out_data,
  output logic                  busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand FIFO
  pair_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ, occ_nxt_c;
  logic               fifo_full_c, fifo_empty_c;
  logic               push_c, pop_c, finish_c;
  pair_t              head_c;

  assign fifo_full_c  = (occ == OCC_W'(FIFO_DEPTH));
  assign fifo_empty_c = (occ == '0);
  assign push_c       = in_vld && !fifo_full_c;
  assign head_c       = mem[rd_ptr];

  always_comb begin
    occ_nxt_c = occ;
    if (push_c && !pop_c) begin
      occ_nxt_c = occ + OCC_W'(1);
    end else if (!push_c && pop_c) begin
      occ_nxt_c = occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{mcand: in0_data, mplier: in1_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ_nxt_c;
    end
  end

  // Load-time operand conditioning: magnitudes and result sign for signed mode
  logic [DATA_W-1:0] mag0_c, mag1_c;
  logic              neg_ld_c;

  always_comb begin
    mag0_c   = head_c.mcand;
    mag1_c   = head_c.mplier;
    neg_ld_c = 1'b0;
    if (SIGNED != 0) begin
      if (head_c.mcand[DATA_W-1])  mag0_c = -head_c.mcand;
      if (head_c.mplier[DATA_W-1]) mag1_c = -head_c.mplier;
      neg_ld_c = head_c.mcand[DATA_W-1] ^ head_c.mplier[DATA_W-1];
    end
  end

  // Shift-add engine
  logic [PROD_W-1:0] acc, mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic [PROD_W-1:0] acc_sum_c, result_c;
  logic [DATA_W-1:0] mplier_sh_c;
  logic              last_c;

  assign acc_sum_c   = mplier[0] ? (acc + mcand) : acc;
  assign mplier_sh_c = mplier >> 1;
  assign result_c    = neg ? -acc_sum_c : acc_sum_c;

`ifdef MULTI_EARLY_DONE_EN
  assign last_c = (cnt == CNT_W'(DATA_W - 1)) || (mplier_sh_c == '0);
`else
  assign last_c = (cnt == CNT_W'(DATA_W - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (pop_c) begin
      acc    <= '0;
      mcand  <= PROD_W'(mag0_c);
      mplier <= mag1_c;
      cnt    <= '0;
      neg    <= neg_ld_c;
    end else if (state == CALC) begin
      acc    <= acc_sum_c;
      mcand  <= mcand << 1;
      mplier <= mplier_sh_c;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty_c) begin
          pop_c     = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_c) begin
          finish_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_rdy) begin
          if (!fifo_empty_c) begin
            pop_c     = 1'b1;
            state_nxt = CALC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; in_rdy and busy track next-cycle occupancy and state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      in_rdy   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      out_vld <= (state_nxt == DONE);
      if (finish_c) out_data <= result_c;
      in_rdy  <= (occ_nxt_c != OCC_W'(FIFO_DEPTH));
      busy    <= (occ_nxt_c != '0) || (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_multi_iter.sv
// Self-checking bench for multi_iter: unsigned and signed instances checked
// against an arithmetic reference model; honours MULTI_EARLY_DONE_EN for latency.
module tb_multi_iter;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          u_in_vld, u_in_rdy, u_out_vld, u_out_rdy, u_busy;
  logic [DW-1:0] u_in0, u_in1;
  logic [2*DW-1:0] u_out_data;
  logic          s_in_vld, s_in_rdy, s_out_vld, s_out_rdy, s_busy;
  logic [DW-1:0] s_in0, s_in1;
  logic [2*DW-1:0] s_out_data;

  multi_iter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_vld(u_in_vld), .in_rdy(u_in_rdy),
    .in0_data(u_in0), .in1_data(u_in1), .out_vld(u_out_vld),
    .out_rdy(u_out_rdy), .out_data(u_out_data), .busy(u_busy)
  );

  multi_iter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_vld(s_in_vld), .in_rdy(s_in_rdy),
    .in0_data(s_in0), .in1_data(s_in1), .out_vld(s_out_vld),
    .out_rdy(s_out_rdy), .out_data(s_out_data), .busy(s_busy)
  );

  // Reference product: plain integer multiply, truncated to 2*DW bits
  function automatic logic [2*DW-1:0] exp_prod(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input bit sgn);
    longint x, y, p;
    x = sgn ? longint'($signed(a)) : longint'(a);
    y = sgn ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return (2*DW)'(p);
  endfunction

  // Number of CALC cycles the multiplier b should take
  function automatic int calc_cycles(input logic [DW-1:0] b, input bit sgn);
    logic [DW-1:0] m;
    int n;
    m = b;
    if (sgn && b[DW-1]) m = -b;
    n = 1;
    for (int i = 0; i < int'(DW); i++) if (m[i]) n = i + 1;
`ifndef MULTI_EARLY_DONE_EN
    n = int'(DW);
`endif
    return n;
  endfunction

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return DW'(1);
      2: return {1'b0, {(DW-1){1'b1}}};
      3: return {1'b1, {(DW-1){1'b0}}};
      4: return '1;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (u_out_vld !== 1'b0) begin failures++; $display("FAIL reset_u_out_vld got=%b want=0", u_out_vld); end
    checks++; if (u_out_data !== '0) begin failures++; $display("FAIL reset_u_out_data got=%h want=0", u_out_data); end
    checks++; if (u_in_rdy !== 1'b1) begin failures++; $display("FAIL reset_u_in_rdy got=%b want=1", u_in_rdy); end
    checks++; if (u_busy !== 1'b0) begin failures++; $display("FAIL reset_u_busy got=%b want=0", u_busy); end
    checks++; if (s_out_vld !== 1'b0) begin failures++; $display("FAIL reset_s_out_vld got=%b want=0", s_out_vld); end
    checks++; if (s_in_rdy !== 1'b1) begin failures++; $display("FAIL reset_s_in_rdy got=%b want=1", s_in_rdy); end
    checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_s_busy got=%b want=0", s_busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_vectors();
    logic [DW-1:0]   va [4] = '{8'd200, 8'd37, 8'd37, 8'd3};
    logic [DW-1:0]   vb [4] = '{8'd255, 8'd1, 8'd0, 8'd128};
    logic [2*DW-1:0] vp [4] = '{16'hC738, 16'h0025, 16'h0000, 16'h0180};
    int t0, n, lat, want;
    u_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (u_in_rdy !== 1'b1) begin failures++; $display("FAIL uvec%0d_in_rdy got=%b want=1", i, u_in_rdy); end
      u_in_vld = 1'b1; u_in0 = va[i]; u_in1 = vb[i]; t0 = cyc;
      tick();
      u_in_vld = 1'b0;
      checks++; if (u_busy !== 1'b1) begin failures++; $display("FAIL uvec%0d_busy_rise got=%b want=1", i, u_busy); end
      n = 0;
      while (u_out_vld !== 1'b1 && n < 40) begin tick(); n++; end
      lat = cyc - t0;
      want = 2 + calc_cycles(vb[i], 1'b0);
      checks++; if (lat != want) begin failures++; $display("FAIL uvec%0d_latency got=%0d want=%0d", i, lat, want); end
      checks++; if (u_out_data !== vp[i]) begin failures++; $display("FAIL uvec%0d_data got=%h want=%h", i, u_out_data, vp[i]); end
      tick();
      checks++; if (u_out_vld !== 1'b0) begin failures++; $display("FAIL uvec%0d_vld_one_cycle got=%b want=0", i, u_out_vld); end
      checks++; if (u_busy !== 1'b0) begin failures++; $display("FAIL uvec%0d_busy_fall got=%b want=0", i, u_busy); end
    end
  endtask

  task automatic test_signed_vectors();
    logic [DW-1:0]   va [4] = '{8'h80, 8'h80, 8'hFF, 8'h00};
    logic [DW-1:0]   vb [4] = '{8'h80, 8'h7F, 8'h01, 8'hFB};
    logic [2*DW-1:0] vp [4] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000};
    int t0, n, lat, want;
    s_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_in_vld = 1'b1; s_in0 = va[i]; s_in1 = vb[i]; t0 = cyc;
      tick();
      s_in_vld = 1'b0;
      n = 0;
      while (s_out_vld !== 1'b1 && n < 40) begin tick(); n++; end
      lat = cyc - t0;
      want = 2 + calc_cycles(vb[i], 1'b1);
      checks++; if (lat != want) begin failures++; $display("FAIL svec%0d_latency got=%0d want=%0d", i, lat, want); end
      checks++; if (s_out_data !== vp[i]) begin failures++; $display("FAIL svec%0d_data got=%h want=%h", i, s_out_data, vp[i]); end
      tick();
      checks++; if (s_out_vld !== 1'b0) begin failures++; $display("FAIL svec%0d_vld_one_cycle got=%b want=0", i, s_out_vld); end
    end
  endtask

  task automatic test_random();
    logic [2*DW-1:0] qu[$], qs[$];
    logic [2*DW-1:0] hdu, hds, e;
    logic [DW-1:0]   a, b;
    logic            hold_u, hold_s;
    hold_u = 1'b0; hold_s = 1'b0; hdu = '0; hds = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i >= 400 && qu.size() == 0 && qs.size() == 0 && u_out_vld !== 1'b1 && s_out_vld !== 1'b1) break;
      // unsigned instance
      if (hold_u) begin
        checks++;
        if (u_out_vld !== 1'b1 || u_out_data !== hdu) begin failures++; $display("FAIL rand_u_hold vld=%b data=%h want vld=1 data=%h", u_out_vld, u_out_data, hdu); end
      end
      u_out_rdy = (i >= 400) || ($urandom_range(0, 3) != 0);
      if (u_out_vld === 1'b1 && u_out_rdy) begin
        checks++;
        if (qu.size() == 0) begin failures++; $display("FAIL rand_u_unexpected got=%h want=none", u_out_data); end
        else begin
          e = qu.pop_front();
          if (u_out_data !== e) begin failures++; $display("FAIL rand_u_data got=%h want=%h", u_out_data, e); end
        end
      end
      hold_u = (u_out_vld === 1'b1) && !u_out_rdy; hdu = u_out_data;
      a = pick_operand(); b = pick_operand();
      u_in_vld = (i < 400) && ($urandom_range(0, 1) == 1); u_in0 = a; u_in1 = b;
      if (u_in_vld && u_in_rdy === 1'b1) qu.push_back(exp_prod(a, b, 1'b0));
      // signed instance
      if (hold_s) begin
        checks++;
        if (s_out_vld !== 1'b1 || s_out_data !== hds) begin failures++; $display("FAIL rand_s_hold vld=%b data=%h want vld=1 data=%h", s_out_vld, s_out_data, hds); end
      end
      s_out_rdy = (i >= 400) || ($urandom_range(0, 3) != 0);
      if (s_out_vld === 1'b1 && s_out_rdy) begin
        checks++;
        if (qs.size() == 0) begin failures++; $display("FAIL rand_s_unexpected got=%h want=none", s_out_data); end
        else begin
          e = qs.pop_front();
          if (s_out_data !== e) begin failures++; $display("FAIL rand_s_data got=%h want=%h", s_out_data, e); end
        end
      end
      hold_s = (s_out_vld === 1'b1) && !s_out_rdy; hds = s_out_data;
      a = pick_operand(); b = pick_operand();
      s_in_vld = (i < 400) && ($urandom_range(0, 1) == 1); s_in0 = a; s_in1 = b;
      if (s_in_vld && s_in_rdy === 1'b1) qs.push_back(exp_prod(a, b, 1'b1));
      tick();
    end
    u_in_vld = 1'b0; s_in_vld = 1'b0;
    checks++;
    if (qu.size() != 0 || qs.size() != 0) begin failures++; $display("FAIL rand_drain pending_u=%0d pending_s=%0d want 0", qu.size(), qs.size()); end
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] qe[$];
    logic [DW-1:0]   qb[$];
    logic [2*DW-1:0] d0, e;
    logic [DW-1:0]   bcur;
    int acc_n, last, got, n, want;
    u_out_rdy = 1'b0; acc_n = 0;
    for (int k = 0; k < 20; k++) begin
      u_in_vld = 1'b1; u_in0 = DW'(k * 7 + 3); u_in1 = DW'(k * 13 + 200);
      if (u_in_rdy === 1'b1) begin
        qe.push_back(exp_prod(u_in0, u_in1, 1'b0)); qb.push_back(u_in1); acc_n++;
      end
      tick();
    end
    u_in_vld = 1'b0;
    checks++; if (acc_n != int'(DEPTH) + 1) begin failures++; $display("FAIL bp_accepted got=%0d want=%0d", acc_n, DEPTH + 1); end
    checks++; if (u_in_rdy !== 1'b0) begin failures++; $display("FAIL bp_in_rdy_full got=%b want=0", u_in_rdy); end
    checks++; if (u_out_vld !== 1'b1) begin failures++; $display("FAIL bp_out_vld got=%b want=1", u_out_vld); end
    d0 = u_out_data;
    repeat (6) tick();
    checks++; if (u_out_vld !== 1'b1 || u_out_data !== d0) begin failures++; $display("FAIL bp_hold vld=%b data=%h want vld=1 data=%h", u_out_vld, u_out_data, d0); end
    u_out_rdy = 1'b1;
    e = qe.pop_front(); void'(qb.pop_front());
    checks++; if (u_out_data !== e) begin failures++; $display("FAIL bp_first_data got=%h want=%h", u_out_data, e); end
    got = 1; last = cyc;
    tick();
    checks++; if (u_in_rdy !== 1'b1) begin failures++; $display("FAIL bp_in_rdy_after_pop got=%b want=1", u_in_rdy); end
    n = 0;
    while (got < int'(DEPTH) + 1 && n < 100) begin
      if (u_out_vld === 1'b1) begin
        checks++;
        if (qe.size() == 0) begin failures++; $display("FAIL bp_unexpected got=%h want=none", u_out_data); end
        else begin
          e = qe.pop_front(); bcur = qb.pop_front();
          if (u_out_data !== e) begin failures++; $display("FAIL bp_data%0d got=%h want=%h", got, u_out_data, e); end
          want = calc_cycles(bcur, 1'b0) + 1;
          checks++;
          if (cyc - last != want) begin failures++; $display("FAIL bp_spacing%0d got=%0d want=%0d", got, cyc - last, want); end
        end
        last = cyc; got++;
      end
      tick(); n++;
    end
    checks++; if (got != int'(DEPTH) + 1) begin failures++; $display("FAIL bp_count got=%0d want=%0d", got, DEPTH + 1); end
    checks++; if (u_busy !== 1'b0 || u_out_vld !== 1'b0) begin failures++; $display("FAIL bp_idle busy=%b vld=%b want 0 0", u_busy, u_out_vld); end
  endtask

  task automatic test_reset_mid();
    int seen, n;
    u_out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      u_in_vld = 1'b1; u_in0 = DW'(9 + k); u_in1 = DW'(9 + k);
      tick();
    end
    u_in_vld = 1'b0;
    repeat (2) tick();
    checks++; if (u_busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b want=1", u_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (u_out_vld !== 1'b0) begin failures++; $display("FAIL rmid_out_vld got=%b want=0", u_out_vld); end
    checks++; if (u_out_data !== '0) begin failures++; $display("FAIL rmid_out_data got=%h want=0", u_out_data); end
    checks++; if (u_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", u_busy); end
    checks++; if (u_in_rdy !== 1'b1) begin failures++; $display("FAIL rmid_in_rdy got=%b want=1", u_in_rdy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (u_out_vld === 1'b1) seen++;
    end
    checks++; if (seen != 0 || u_busy !== 1'b0) begin failures++; $display("FAIL rmid_no_output vld_cycles=%0d busy=%b want 0 0", seen, u_busy); end
    u_in_vld = 1'b1; u_in0 = DW'(6); u_in1 = DW'(7);
    tick();
    u_in_vld = 1'b0;
    n = 0;
    while (u_out_vld !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (u_out_vld !== 1'b1 || u_out_data !== 16'h002A) begin failures++; $display("FAIL rmid_new_pair vld=%b data=%h want vld=1 data=002a", u_out_vld, u_out_data); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    u_in_vld = 1'b0; u_in0 = '0; u_in1 = '0; u_out_rdy = 1'b0;
    s_in_vld = 1'b0; s_in0 = '0; s_in1 = '0; s_out_rdy = 1'b0;
    repeat (2) tick();
    test_reset();
    test_unsigned_vectors();
    test_signed_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_iter.md
# multi_iter

Parametrised iterative shift-add multiplier, the next-generation multiply unit for the datapath. It accepts operand pairs through a valid/ready handshake into an internal operand FIFO and multiplies one multiplier bit per cycle. It supports signed or unsigned operands and holds each product until the downstream consumer takes it. It replaces the fixed 8-bit unit wherever a wider operand, back-pressure or signed arithmetic is needed.

## Interface
- DATA_W, 8, operand width in bits (>= 2)
- FIFO_DEPTH, 4, operand FIFO entries (power of 2, >= 2)
- SIGNED, 0, 1 = operands and product are two's complement; 0 = unsigned
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_vld  input  1  operand pair valid
- in_rdy  output  1  FIFO can accept a pair; equals ~fifo_full
- in0_data  input  DATA_W  multiplicand
- in1_data  input  DATA_W  multiplier
- out_vld  output  1  product valid
- out_rdy  input  1  consumer takes product
- out_data  output  2*DATA_W  product
- busy  output  1  FIFO non-empty or engine not IDLE

## Operation
- Push: in_vld & in_rdy writes {in0_data, in1_data} to the FIFO tail. There is no bypass, so a pair is never popped in the cycle it is pushed.
- Full FIFO: in_rdy=0 even if a pop occurs in the same cycle. A pair offered while in_rdy=0 is ignored.
- FSM states: IDLE, CALC, DONE.
- IDLE: when the FIFO is non-empty, pop the head, load the engine and go to CALC.
- Load: with SIGNED=1, the engine stores the magnitudes of both operands and neg = sign0 ^ sign1. -2^(DATA_W-1) maps to the unsigned magnitude 2^(DATA_W-1). With SIGNED=0, the engine stores the raw operands and neg=0.
- Accumulator and counter at load: accumulator (2*DATA_W) = 0, iteration counter = 0.
- CALC, each cycle:
  - if m[0]: acc += mcand, where mcand is zero-extended to 2*DATA_W
  - mcand <<= 1; m >>= 1; cnt++
- CALC exit: after the cycle with cnt == DATA_W-1, go to DONE. The early-exit rule is under Configuration.
- On the CALC→DONE edge, out_data is registered as neg ? -acc_final : acc_final, truncated to 2*DATA_W bits. The result is exact for all inputs.
- DONE: out_vld=1, and out_data is held stable while out_rdy=0.
- Leaving DONE on out_rdy=1:
  - FIFO non-empty: pop in the same cycle and go to CALC (no bubble).
  - FIFO empty: go to IDLE.
- Results leave in strict arrival order.
- Reset values (async assert): state=IDLE, FIFO empty, out_vld=0, out_data=0, in_rdy=1, busy=0. Asserting reset mid-operation discards all pending pairs and the in-flight result.

## Timing
- Pair accepted in cycle T into an empty FIFO with the engine IDLE:
  - pop at T+1
  - CALC from T+2
  - out_vld at T+DATA_W+2 (full iteration)
- Sustained throughput with out_rdy=1: one product every DATA_W+1 cycles.
- Capacity: FIFO_DEPTH pairs queued plus one in the engine.
- busy rises the cycle after the first accept, because FIFO occupancy is registered. It falls in the cycle after the final DONE handshake when the FIFO is empty.

## Configuration
- MULTI_EARLY_DONE_EN defined: CALC also exits after any cycle in which the post-shift remaining multiplier is zero. CALC then takes max(1, index of the highest set bit of |in1|, plus 1) cycles. A zero multiplier takes 1 CALC cycle and yields 0. Variable latency; order is still preserved.
- MULTI_EARLY_DONE_EN undefined: CALC always takes exactly DATA_W cycles, giving fixed latency.

## Test plan
- SIGNED=0, DATA_W=8: 200 × 255 accepted at T, out_rdy=1 -> out_vld at T+10, out_data=0xC738. Without the macro, out_vld is high for exactly 1 cycle.
- SIGNED=1, DATA_W=8:
  - -128 × -128 -> 0x4000
  - -128 × 127 -> 0xC080
  - -1 × 1 -> 0xFFFF
  - 0 × -5 -> 0x0000
- MULTI_EARLY_DONE_EN, SIGNED=0:
  - 37 × 1 accepted at T -> out_vld at T+3 with 0x0025
  - 37 × 0 -> out_vld at T+3 with 0x0000
  - 3 × 128 -> out_vld at T+10 with 0x0180
- Back-pressure, FIFO_DEPTH=4, out_rdy=0, in_vld held high with distinct pairs:
  - exactly 5 pairs are accepted, then in_rdy=0 and out_data stays stable
  - after out_rdy rises, all 5 products arrive in order, spaced 9 cycles apart
  - in_rdy returns to 1 in the cycle after the first pop
- Reset mid-CALC with 2 pairs queued: rst_n low for 1 cycle -> out_vld=0, out_data=0, busy=0, in_rdy=1 immediately, and no product appears afterwards. A new pair 6 × 7 yields 0x002A.
